// File: rtl/halflife_decay_ctrl.sv
// Halving-decay command initiator for an n-bit up/down/load counter.
// Define HALFLIFE_ROUND_EN to round each halving target half up instead of flooring it.
module halflife_decay_ctrl #(
  parameter int N  = 4,
  parameter int PW = 8,
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  preset,
  input  logic [PW-1:0] period,
  input  logic [N-1:0]  cnt_in,
  output logic          load,
  output logic [N-1:0]  ld_val,
  output logic          down,
  output logic          busy,
  output logic          done,
  output logic [HW-1:0] halvings
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE_L,
    PERIOD,
    DOWN,
    SETTLE_D,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] period_r;
  logic [PW-1:0] timer;
  logic [N-1:0]  target;
  logic [N-1:0]  half_cnt;

`ifdef HALFLIFE_ROUND_EN
  // Sum is formed one bit wider so the maximum count cannot wrap before the shift.
  always_comb begin
    half_cnt = N'(({1'b0, cnt_in} + (N+1)'(1)) >> 1);
    if (cnt_in == N'(1)) half_cnt = '0;
  end
`else
  always_comb begin
    half_cnt = cnt_in >> 1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      load     <= 1'b0;
      ld_val   <= '0;
      down     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      halvings <= '0;
      timer    <= '0;
      target   <= '0;
      period_r <= '0;
    end else begin
      // Strobes are single-cycle; each state re-asserts them only on its transition.
      load <= 1'b0;
      down <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ld_val   <= preset;
            period_r <= (period == '0) ? PW'(1) : period;
            halvings <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            load     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          ld_val <= '0;
          state  <= SETTLE_L;
        end
        SETTLE_L: begin
          if (cnt_in == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            timer <= '0;
            state <= PERIOD;
          end
        end
        PERIOD: begin
          if (timer == period_r - PW'(1)) begin
            target <= half_cnt;
            state  <= DOWN;
          end else begin
            timer <= timer + PW'(1);
          end
        end
        DOWN: begin
          if (cnt_in > target) begin
            down  <= 1'b1;
            state <= SETTLE_D;
          end else begin
            if (halvings != '1) halvings <= halvings + HW'(1);
            if (target == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              timer <= '0;
              state <= PERIOD;
            end
          end
        end
        SETTLE_D: begin
          state <= DOWN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
